// File: rtl/sim_dram_r_delay_buffer_if.sv
// AXI4 R-channel bundle between the DRAM model, the delay buffer and the SoC master.
// Handshake: a beat transfers on a posedge where valid && ready; once valid rises, valid and bits hold until that transfer.
interface sim_dram_r_delay_buffer_if #(
  parameter int DATA_BITS = 64,
  parameter int ID_BITS   = 5
);
  logic                 valid;
  logic                 ready;
  logic [DATA_BITS-1:0] bits_data;
  logic [ID_BITS-1:0]   bits_id;
  logic [1:0]           bits_resp;
  logic                 bits_last;

  modport master (output valid, bits_data, bits_id, bits_resp, bits_last, input ready);
  modport slave  (input valid, bits_data, bits_id, bits_resp, bits_last, output ready);
endinterface

// File: rtl/sim_dram_r_delay_buffer.sv
// Fixed-latency in-order FIFO for simulated DRAM read beats; each entry counts down before release.
// Optional statistics counters are built when SIM_DRAM_R_DELAY_BUFFER_STATS_EN is defined.
module sim_dram_r_delay_buffer #(
  parameter int DATA_BITS = 64,
  parameter int ID_BITS   = 5,
  parameter int DEPTH     = 8,
  parameter int LATENCY   = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  sim_dram_r_delay_buffer_if.slave   s_r,
  sim_dram_r_delay_buffer_if.master  m_r,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [31:0]                stat_beats,
  output logic [31:0]                stat_stalls
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL = OW'(DEPTH);
  localparam logic [7:0] LOAD = 8'(LATENCY - 1);

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic [ID_BITS-1:0]   id;
    logic [1:0]           resp;
    logic                 last;
  } beat_t;

  beat_t         mem [DEPTH];
  logic [7:0]    cnt [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ, occ_nxt;
  logic          ready_q;
  logic          head_valid;
  logic          push, pop;

  assign head_valid = (occ != '0) && (cnt[rd_ptr] == 8'd0);
  assign push       = s_r.valid && ready_q;
  assign pop        = head_valid && m_r.ready;

  always_comb begin
    occ_nxt = occ;
    if (push && !pop)      occ_nxt = occ + OW'(1);
    else if (pop && !push) occ_nxt = occ - OW'(1);
  end

  // Free entries always hold a zero count (a head pops only at zero), so
  // decrementing every nonzero count is the same as touching occupied ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
        cnt[i] <= 8'd0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      ready_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && wr_ptr == AW'(i)) begin
          mem[i] <= '{data: s_r.bits_data, id: s_r.bits_id, resp: s_r.bits_resp, last: s_r.bits_last};
          cnt[i] <= LOAD;
        end else if (cnt[i] != 8'd0) begin
          cnt[i] <= cnt[i] - 8'd1;
        end
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      occ     <= occ_nxt;
      // Registered ready: a pop in a full cycle frees space only from the next cycle.
      ready_q <= (occ_nxt != FULL);
    end
  end

  assign s_r.ready     = ready_q;
  assign m_r.valid     = head_valid;
  assign m_r.bits_data = mem[rd_ptr].data;
  assign m_r.bits_id   = mem[rd_ptr].id;
  assign m_r.bits_resp = mem[rd_ptr].resp;
  assign m_r.bits_last = mem[rd_ptr].last;
  assign occupancy     = occ;

`ifdef SIM_DRAM_R_DELAY_BUFFER_STATS_EN
  logic [31:0] beats_q, stalls_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      beats_q  <= '0;
      stalls_q <= '0;
    end else begin
      if (pop && beats_q != 32'hFFFF_FFFF) beats_q <= beats_q + 32'd1;
      if (head_valid && !m_r.ready && stalls_q != 32'hFFFF_FFFF) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign stat_beats  = beats_q;
  assign stat_stalls = stalls_q;
`else
  assign stat_beats  = 32'd0;
  assign stat_stalls = 32'd0;
`endif
endmodule

// File: tb/tb_sim_dram_r_delay_buffer.sv
// Randomized bench: a queue model predicts beat order, release time, ready, occupancy and statistics.
module tb_sim_dram_r_delay_buffer;
  localparam int DB = 64;
  localparam int IB = 5;
  localparam int D  = 8;
  localparam int L  = 4;
  localparam int BW = DB + IB + 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  occupancy;
  logic [31:0] stat_beats, stat_stalls;

  sim_dram_r_delay_buffer_if #(.DATA_BITS(DB), .ID_BITS(IB)) s_r ();
  sim_dram_r_delay_buffer_if #(.DATA_BITS(DB), .ID_BITS(IB)) m_r ();

  sim_dram_r_delay_buffer #(.DATA_BITS(DB), .ID_BITS(IB), .DEPTH(D), .LATENCY(L)) dut (
    .clock       (clock),
    .reset       (reset),
    .s_r         (s_r),
    .m_r         (m_r),
    .occupancy   (occupancy),
    .stat_beats  (stat_beats),
    .stat_stalls (stat_stalls)
  );

  // Clock and reset-relative edge count
  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) begin
    if (!reset) edge_cnt = 0;
    else        edge_cnt = edge_cnt + 1;
  end

  // Scoreboard state
  logic [BW-1:0] exp_q[$];
  int            acc_q[$];
  int            last_pop = 0;
  int            model_beats = 0;
  int            model_stalls = 0;
  int            tests = 0;
  int            fails = 0;
  int            seq = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a beat may leave no earlier than LATENCY-1 edges after acceptance
  // and no earlier than the edge that popped its predecessor.
  always @(negedge clock) begin
    logic exp_v;
    int   rel;
    if (!reset) begin
      exp_q.delete();
      acc_q.delete();
      last_pop     = 0;
      model_beats  = 0;
      model_stalls = 0;
    end else begin
      exp_v = 1'b0;
      if (exp_q.size() != 0) begin
        rel   = (acc_q[0] + L - 1 > last_pop) ? acc_q[0] + L - 1 : last_pop;
        exp_v = (edge_cnt >= rel);
      end
      check("m_valid", 128'(m_r.valid), 128'(exp_v));
      check("occupancy", 128'(occupancy), 128'(exp_q.size()));
      check("s_ready", 128'(s_r.ready), 128'(edge_cnt >= 1 && exp_q.size() != D));
      if (m_r.valid && exp_q.size() != 0)
        check("m_bits", 128'({m_r.bits_data, m_r.bits_id, m_r.bits_resp, m_r.bits_last}), 128'(exp_q[0]));
      if (exp_v && !m_r.ready) model_stalls++;
      if (m_r.valid && m_r.ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        last_pop = edge_cnt + 1;
        model_beats++;
      end
      if (s_r.valid && s_r.ready) begin
        exp_q.push_back({s_r.bits_data, s_r.bits_id, s_r.bits_resp, s_r.bits_last});
        acc_q.push_back(edge_cnt + 1);
      end
    end
  end

  // Driver tasks
  task automatic new_beat();
    s_r.valid     = 1'b1;
    s_r.bits_data = {$urandom(), 32'(seq)};
    s_r.bits_id   = IB'($urandom_range(31));
    s_r.bits_resp = 2'($urandom_range(3));
    s_r.bits_last = ($urandom_range(3) == 0);
    seq++;
  endtask

  task automatic run_traffic(input int n, input int pv, input int pr);
    logic hs;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      hs = s_r.valid && s_r.ready;
      @(posedge clock);
      #1;
      if (!s_r.valid || hs) begin
        if ($urandom_range(99) < pv) new_beat();
        else s_r.valid = 1'b0;
      end
      m_r.ready = ($urandom_range(99) < pr);
    end
  endtask

  task automatic drain(input int max_cycles);
    int k;
    @(negedge clock);
    if (s_r.valid && s_r.ready) @(posedge clock);
    #1;
    s_r.valid = 1'b0;
    m_r.ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < max_cycles) begin
      @(posedge clock);
      k++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d beats left, expected 0", exp_q.size());
    end
    repeat (2) @(negedge clock);
    #1;
  endtask

  task automatic check_stats();
`ifdef SIM_DRAM_R_DELAY_BUFFER_STATS_EN
    check("stat_beats", 128'(stat_beats), 128'(model_beats));
    check("stat_stalls", 128'(stat_stalls), 128'(model_stalls));
`else
    check("stat_beats", 128'(stat_beats), 128'(0));
    check("stat_stalls", 128'(stat_stalls), 128'(0));
`endif
  endtask

  task automatic check_reset_outputs();
    check("rst_m_valid", 128'(m_r.valid), 128'(0));
    check("rst_s_ready", 128'(s_r.ready), 128'(0));
    check("rst_occupancy", 128'(occupancy), 128'(0));
    check("rst_m_bits", 128'({m_r.bits_data, m_r.bits_id, m_r.bits_resp, m_r.bits_last}), 128'(0));
    check("rst_stat_beats", 128'(stat_beats), 128'(0));
    check("rst_stat_stalls", 128'(stat_stalls), 128'(0));
  endtask

  initial begin
    s_r.valid = 1'b0; s_r.bits_data = '0; s_r.bits_id = '0; s_r.bits_resp = '0; s_r.bits_last = 1'b0;
    m_r.ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs();
    reset = 1'b1;
    repeat (4) @(posedge clock);

    // Single beat, exact release timing checked by the monitor
    #1;
    s_r.valid = 1'b1; s_r.bits_data = 64'hDEAD_BEEF; s_r.bits_id = 5'd3;
    s_r.bits_resp = 2'd0; s_r.bits_last = 1'b1;
    m_r.ready = 1'b1;
    @(posedge clock);
    #1;
    s_r.valid = 1'b0;
    repeat (L + 3) @(posedge clock);
    check("single_delivered", 128'(model_beats), 128'(1));
    drain(50);
    check_stats();

    // Full-rate burst with ready high, then fill with master stalled and release
    run_traffic(20, 100, 100);
    run_traffic(14, 100, 0);
    check("full_occupancy", 128'(occupancy), 128'(D));
    run_traffic(6, 100, 100);
    drain(100);
    check_stats();

    // Reset mid-stream with beats buffered
    run_traffic(4, 100, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    s_r.valid = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    m_r.ready = 1'b1;
    repeat (20) @(posedge clock);
    check("post_reset_beats", 128'(model_beats), 128'(0));

    // Random mixed traffic
    run_traffic(3000, 60, 60);
    drain(500);
    check_stats();
    check("stall_seen", 128'(model_stalls > 0), 128'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end
endmodule

// File: doc/sim_dram_r_delay_buffer.md
Name: sim_dram_r_delay_buffer

Overview:
- Read-response buffer that sits directly downstream of the simulated DRAM model's AXI4 R channel and feeds the SoC-side master.
- Accepts R beats from the DRAM model, holds each for a fixed programmable latency in a small FIFO, then presents them in order to the master.
- Adds extra memory latency and decouples DRAM-model backpressure from master backpressure in simulation.

Parameters:
- DATA_BITS, 64, R data width.
- ID_BITS, 5, AXI ID width.
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- LATENCY, 4, cycles from slave-side acceptance to master-side valid; range 1..255.

Ports:
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset; 0 = in reset.
- s_r_valid  input  1  beat valid from the DRAM model.
- s_r_ready  output  1  buffer can accept a beat.
- s_r_bits_data  input  DATA_BITS  read data.
- s_r_bits_id  input  ID_BITS  read ID.
- s_r_bits_resp  input  2  AXI resp.
- s_r_bits_last  input  1  last beat of burst.
- m_r_valid  output  1  beat valid to the master.
- m_r_ready  input  1  master accepts the beat.
- m_r_bits_data  output  DATA_BITS  read data.
- m_r_bits_id  output  ID_BITS  read ID.
- m_r_bits_resp  output  2  AXI resp.
- m_r_bits_last  output  1  last flag.
- occupancy  output  clog2(DEPTH)+1  entries currently held.
- stat_beats  output  32  beats delivered (optional feature).
- stat_stalls  output  32  master backpressure cycles (optional feature).

Behaviour:
- Reset, asserted asynchronously: all outputs 0, FIFO emptied, pointers and per-entry countdowns cleared.
  - Reset mid-operation drops every buffered beat; no beat is emitted after deassertion.
- Storage: DEPTH entries. Each entry holds {data, id, resp, last} plus an 8-bit countdown.
  - Read/write pointers are clog2(DEPTH) bits and wrap naturally.
  - occupancy is a separate counter, 0..DEPTH.
- s_r_ready = (occupancy != DEPTH), driven from registered state only.
  - A pop in the same cycle does not make room when full: no bypass, and no combinational ready-to-ready or valid-to-valid path.
- Push on posedge when s_r_valid && s_r_ready: write the entry at the write pointer, load its countdown with LATENCY-1, advance the write pointer.
- Each posedge, every occupied entry whose countdown is nonzero decrements by 1; the countdown saturates at 0.
  - A freshly pushed entry does not decrement on its own push edge.
- m_r_valid = (occupancy != 0) && (head countdown == 0). m_r_bits_* = head entry fields.
  - Result: a beat accepted at edge k drives m_r_valid high from edge k+LATENCY-1 onward. LATENCY=1 means valid the cycle after acceptance.
- Pop on posedge when m_r_valid && m_r_ready: advance the read pointer.
  - The next entry may already have countdown 0, giving back-to-back beats at full rate after the latency is filled.
- Simultaneous push and pop: occupancy is unchanged; both pointers advance.
- Once m_r_valid is high, it and m_r_bits_* stay stable until the beat is popped (AXI rule).
- Beat order, ID, resp and last pass through unmodified. No reordering, no ID interleaving changes.
- Steady-state throughput: 1 beat/cycle when DEPTH >= LATENCY+1. Smaller DEPTH throttles the stream and must not lose data.

Optional Feature:
- Macro SIM_DRAM_R_DELAY_BUFFER_STATS_EN.
- Defined:
  - stat_beats increments on each pop.
  - stat_stalls increments each cycle with m_r_valid && !m_r_ready.
  - Both are 32-bit, saturate at 0xFFFFFFFF and clear on reset.
- Undefined: counters are not built; stat_beats and stat_stalls are tied to 0.

Test Plan:
- LATENCY=4, single beat {data=0xDEADBEEF, id=3, resp=0, last=1} accepted at edge 10, m_r_ready=1 -> m_r_valid rises after edge 13 with identical fields, held 1 cycle, occupancy returns 0.
- LATENCY=1, 16-beat burst, valid every cycle, m_r_ready=1 -> s_r_ready never drops, output is 16 consecutive beats, data order preserved, last only on beat 16.
- DEPTH=8, m_r_ready=0, 10 beats offered -> s_r_ready falls after 8 accepted, occupancy=8; raise ready -> all 10 delivered in order, no duplicates.
- Full buffer, m_r_ready=1 and s_r_valid=1 in the same cycle -> pop occurs but no push that cycle; push succeeds the next cycle.
- 3 beats buffered, reset pulled low mid-stream for 2 cycles -> all outputs 0 immediately; after release occupancy=0 and no stale beat is emitted.
- STATS_EN defined, 5 beats with 7 stall cycles -> stat_beats=5, stat_stalls=7. Undefined -> both read 0.
